bus_arbiter2: RTL and testbench
===============================

Name: bus_arbiter2

Overview:
- Two-master, one-slave arbiter for the CPU memory bus: read/write strobes, waitrequest stall, 32-bit address/data, 4-bit byteenable.
- Master 0 is the CPU core; master 1 is a secondary master such as DMA or a video fetcher.
- Sits between the masters and the memory/peripheral fabric, with registered round-robin grant and a per-transfer watchdog timeout.

Parameters:
- AW, 32, address width.
- DW, 32, data width (byteenable width = DW/8).
- TIMEOUT, 255, max stalled cycles per transfer before forced abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- m0_address  in  AW  master 0 address
- m0_read, m0_write  in  1 each  master 0 strobes
- m0_writedata  in  DW  master 0 write data
- m0_byteenable  in  DW/8  master 0 lane enables
- m0_readdata  out  DW  read data to master 0
- m0_waitrequest  out  1  stall to master 0
- m1_*  same set as m0_* for master 1
- s_address  out  AW  slave address
- s_read, s_write  out  1 each  slave strobes
- s_writedata  out  DW  slave write data
- s_byteenable  out  DW/8  slave lane enables
- s_readdata  in  DW  slave read data
- s_waitrequest  in  1  slave stall
- grant  out  2  one-hot current owner; 00 when idle
- bus_error  out  1  one-cycle pulse on timeout abort
- err_master  out  1  master index of the last aborted transfer (held)

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low.
- FSM states: IDLE, OWN0, OWN1. Registers: state, last_owner, wd_cnt, err_master, bus_error.
- Reset values: state=IDLE, last_owner=1 (master 0 wins first tie), wd_cnt=0, bus_error=0, err_master=0.
  - Outputs at reset: grant=00, s_read=s_write=0, s_address/s_writedata/s_byteenable=0, both m*_waitrequest=1, m*_readdata=0.
- Request definition: req_i = mi_read | mi_write. Masters hold strobes and address/data until they see waitrequest low.
- IDLE transitions:
  - Only one request: go to that OWN state.
  - Both requesting: go to OWN of the master != last_owner.
  - No request: stay.
  - Arbitration latency: request seen in cycle N, slave strobes asserted in cycle N+1.
- OWNi datapath: s_* driven combinationally from mi_*; mi_readdata = s_readdata; mi_waitrequest = s_waitrequest. Non-owner sees waitrequest=1, readdata=0.
- Completion: cycle in which req_i=1 and s_waitrequest=0. Next state IDLE, last_owner<=i, wd_cnt<=0. One idle bubble between transfers, even for back-to-back requests from the same master.
- Owner drops its request before completion (protocol violation): next state IDLE, last_owner unchanged, no error.
- Watchdog (TIMEOUT>0):
  - wd_cnt increments each OWN cycle with s_waitrequest=1.
  - When wd_cnt==TIMEOUT-1 and still stalled: in that cycle drive mi_waitrequest=0 and mi_readdata = all-ones, and force s_read=s_write=0.
  - Next cycle: state=IDLE, bus_error=1 for exactly one cycle, err_master=i, last_owner=i.
- Reset mid-transfer: asynchronously to IDLE; slave strobes drop immediately; the transfer is lost.
- bus_error is registered; it is never asserted while reset_n=0.

Optional Feature:
- Macro BUS_LOCK_EN adds input m0_lock (1 bit).
- With macro:
  - While in OWN0 with m0_lock=1, completion returns to OWN0 directly (no bubble, no re-arbitration); master 1 is starved until m0_lock=0. Used for CPU read-modify-write atomics.
  - Lock is ignored in OWN1 and in IDLE: lock alone never claims the bus.
  - A timeout abort clears ownership regardless of lock.
- Without macro: port absent; behaviour exactly as above.

Decomposition:
- Shared package bus_pkg:
  - FSM state typedef/encodings (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2).
  - Master index constants M_CPU=0, M_AUX=1.
  - Abort readdata constant BUS_ABORT_DATA = all-ones.
- One sub-module bus_watchdog: TIMEOUT-parameterised counter with clear/enable inputs and expire output. The arbiter instantiates it once.

Test Plan:
- Reset released, m0_read at 0x100, slave waitrequest low after 2 cycles, readdata 0xDEADBEEF → grant=01 one cycle after request; m0 receives 0xDEADBEEF; return to grant=00 next cycle.
- m0_read and m1_write asserted in the same IDLE cycle → m0 served first, then IDLE bubble, then m1 (grant 01 → 00 → 10); s_writedata equals m1 data, byteenable 4'b0011 passed through.
- Continuous requests from both masters over 6 transfers → strict alternation 0,1,0,1,0,1; m1_waitrequest=1 throughout every OWN0 cycle.
- TIMEOUT=4, slave holds waitrequest=1 forever for m1 read → on 4th stall cycle m1 sees waitrequest=0 and readdata 0xFFFFFFFF; next cycle bus_error pulses once, err_master=1, s_read=0.
- reset_n pulsed low mid-OWN0 stall → s_read low immediately (same cycle), grant=00, bus_error stays 0.
- BUS_LOCK_EN: m0_lock=1 over 3 m0 writes with m1 requesting → three m0 completions with no bubble; m1 granted only after the write during which lock drops.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM encodings,
// master indices and the data pattern returned on a watchdog abort.
package bus_pkg;

    // Arbiter ownership state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } bus_state_e;

    // Master indices (also the encoding of last_owner / err_master)
    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    // All-ones read data handed to a master whose transfer was aborted;
    // consumers slice off the low DW bits.
    localparam int unsigned BUS_MAX_DW     = 1024;
    localparam logic [BUS_MAX_DW-1:0] BUS_ABORT_DATA = '1;

endpackage : bus_pkg

// File: rtl/bus_watchdog.sv
// Per-transfer stall counter. Counts enabled cycles since the last clear
// and flags expiry combinationally in the enabled cycle that would be the
// TIMEOUT-th stall. TIMEOUT=0 removes the counter and never expires.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire_c
);

    generate
        if (TIMEOUT == 0) begin : g_off
            // Watchdog disabled: nothing ever expires
            assign o_expire_c = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] r_cnt;

            // Stall counter; clear has priority so an expiring cycle resets it
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (i_clr) begin
                    r_cnt <= '0;
                end else if (i_en) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign o_expire_c = i_en && (r_cnt == LAST);
        end
    endgenerate

endmodule : bus_watchdog

// File: rtl/bus_arbiter2.sv
// Two-master / one-slave bus arbiter with registered round-robin grant,
// one idle bubble between transfers and a per-transfer stall watchdog.
// Optional macro BUS_LOCK_EN adds m0_lock, letting master 0 chain
// transfers without re-arbitration (read-modify-write atomics).
module bus_arbiter2
    import bus_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef BUS_LOCK_EN
    input  logic              m0_lock,
`endif
    input  logic [AW-1:0]     m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DW-1:0]     m0_writedata,
    input  logic [DW/8-1:0]   m0_byteenable,
    output logic [DW-1:0]     m0_readdata,
    output logic              m0_waitrequest,
    input  logic [AW-1:0]     m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DW-1:0]     m1_writedata,
    input  logic [DW/8-1:0]   m1_byteenable,
    output logic [DW-1:0]     m1_readdata,
    output logic              m1_waitrequest,
    output logic [AW-1:0]     s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DW-1:0]     s_writedata,
    output logic [DW/8-1:0]   s_byteenable,
    input  logic [DW-1:0]     s_readdata,
    input  logic              s_waitrequest,
    output logic [1:0]        grant,
    output logic              bus_error,
    output logic              err_master
);

    localparam int unsigned BW = DW / 8;
    localparam logic [DW-1:0] ABORT_DATA = BUS_ABORT_DATA[DW-1:0];

    bus_state_e r_state;
    bus_state_e w_state_nxt;
    logic       r_last_owner;
    logic       r_err_master;
    logic       r_bus_error;

    logic       w_req0;
    logic       w_req1;
    logic       w_owning;
    logic       w_owner;
    logic       w_own_req;
    logic       w_stall;
    logic       w_done;
    logic       w_drop;
    logic       w_abort;
    logic       w_wd_clr;
    logic       w_lock;

    // Request decode and per-cycle transfer status of the current owner
    assign w_req0    = m0_read | m0_write;
    assign w_req1    = m1_read | m1_write;
    assign w_owning  = (r_state == OWN0) || (r_state == OWN1);
    assign w_owner   = (r_state == OWN1) ? M_AUX : M_CPU;
    assign w_own_req = (r_state == OWN1) ? w_req1 : w_req0;
    assign w_stall   = w_owning && w_own_req && s_waitrequest;
    assign w_done    = w_owning && w_own_req && !s_waitrequest;
    assign w_drop    = w_owning && !w_own_req;
    assign w_wd_clr  = !w_owning || w_done || w_drop || w_abort;

`ifdef BUS_LOCK_EN
    assign w_lock = m0_lock;
`else
    assign w_lock = 1'b0;
`endif

    bus_watchdog #(
        .TIMEOUT    (TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clr      (w_wd_clr),
        .i_en       (w_stall),
        .o_expire_c (w_abort)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state arbitration and owner-muxed datapath
    always_comb begin
        w_state_nxt    = r_state;
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_readdata    = '0;
        m0_waitrequest = 1'b1;
        m1_readdata    = '0;
        m1_waitrequest = 1'b1;

        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    w_state_nxt = (r_last_owner == M_CPU) ? OWN1 : OWN0;
                end else if (w_req0) begin
                    w_state_nxt = OWN0;
                end else if (w_req1) begin
                    w_state_nxt = OWN1;
                end
            end

            OWN0: begin
                s_address      = m0_address;
                s_read         = m0_read  && !w_abort;
                s_write        = m0_write && !w_abort;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_readdata    = w_abort ? ABORT_DATA : s_readdata;
                m0_waitrequest = w_abort ? 1'b0 : s_waitrequest;
                if (w_abort || w_drop) begin
                    w_state_nxt = IDLE;
                end else if (w_done) begin
                    w_state_nxt = w_lock ? OWN0 : IDLE;
                end
            end

            OWN1: begin
                s_address      = m1_address;
                s_read         = m1_read  && !w_abort;
                s_write        = m1_write && !w_abort;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_readdata    = w_abort ? ABORT_DATA : s_readdata;
                m1_waitrequest = w_abort ? 1'b0 : s_waitrequest;
                if (w_abort || w_drop || w_done) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Round-robin history and abort reporting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_owner <= M_AUX;
            r_err_master <= M_CPU;
            r_bus_error  <= 1'b0;
        end else begin
            r_bus_error <= w_abort;
            if (w_abort) begin
                r_err_master <= w_owner;
                r_last_owner <= w_owner;
            end else if (w_done) begin
                r_last_owner <= w_owner;
            end
        end
    end

    assign grant      = {r_state == OWN1, r_state == OWN0};
    assign bus_error  = r_bus_error;
    assign err_master = r_err_master;

    // Byte-lane width is tied to the data width
    if (BW * 8 != DW) begin : g_bad_dw
        $error("DW must be a multiple of 8");
    end

endmodule : bus_arbiter2

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2 (TIMEOUT=4). Inputs change 2 time units
// after the rising edge; outputs are sampled 1 unit later.
module tb_bus_arbiter2;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n;
`ifdef BUS_LOCK_EN
    logic          m0_lock;
`endif
    logic [AW-1:0] m0_address,    m1_address;
    logic          m0_read,       m1_read;
    logic          m0_write,      m1_write;
    logic [DW-1:0] m0_writedata,  m1_writedata;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic [DW-1:0] m0_readdata,   m1_readdata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [AW-1:0] s_address;
    logic          s_read, s_write;
    logic [DW-1:0] s_writedata;
    logic [BW-1:0] s_byteenable;
    logic [DW-1:0] s_readdata;
    logic          s_waitrequest;
    logic [1:0]    grant;
    logic          bus_error;
    logic          err_master;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_arbiter2 #(
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT        (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
`ifdef BUS_LOCK_EN
        .m0_lock        (m0_lock),
`endif
        .m0_address     (m0_address),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_byteenable  (m0_byteenable),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (m1_address),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_byteenable  (m1_byteenable),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_writedata    (s_writedata),
        .s_byteenable   (s_byteenable),
        .s_readdata     (s_readdata),
        .s_waitrequest  (s_waitrequest),
        .grant          (grant),
        .bus_error      (bus_error),
        .err_master     (err_master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet_inputs();
`ifdef BUS_LOCK_EN
        m0_lock       = 1'b0;
`endif
        m0_address    = '0;  m1_address    = '0;
        m0_read       = 1'b0; m1_read      = 1'b0;
        m0_write      = 1'b0; m1_write     = 1'b0;
        m0_writedata  = '0;  m1_writedata  = '0;
        m0_byteenable = '0;  m1_byteenable = '0;
        s_readdata    = '0;
        s_waitrequest = 1'b1;
    endtask

    // Safety net in case the sequence below ever stalls
    initial begin
        #200000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // ---------------- reset values (request present during reset) ----
        reset_n = 1'b0;
        quiet_inputs();
        m0_read    = 1'b1;
        m0_address = 32'h100;
        #3;
        chk("rst_grant",   32'(grant),          32'd0);
        chk("rst_s_read",  32'(s_read),         32'd0);
        chk("rst_s_write", 32'(s_write),        32'd0);
        chk("rst_s_addr",  32'(s_address),      32'd0);
        chk("rst_s_wdata", 32'(s_writedata),    32'd0);
        chk("rst_s_be",    32'(s_byteenable),   32'd0);
        chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("rst_m0_rd",   32'(m0_readdata),    32'd0);
        chk("rst_m1_rd",   32'(m1_readdata),    32'd0);
        chk("rst_berr",    32'(bus_error),      32'd0);
        chk("rst_errm",    32'(err_master),     32'd0);

        // ---------------- single m0 read, 2 stall cycles -----------------
        tick();
        reset_n = 1'b1;
        #1;
        chk("t1_idle_grant", 32'(grant),          32'd0);
        chk("t1_idle_wait",  32'(m0_waitrequest), 32'd1);
        tick();
        #1;
        chk("t1_grant",      32'(grant),          32'd1);
        chk("t1_s_read",     32'(s_read),         32'd1);
        chk("t1_s_addr",     32'(s_address),      32'h100);
        chk("t1_stall1",     32'(m0_waitrequest), 32'd1);
        tick();
        #1;
        chk("t1_stall2",     32'(m0_waitrequest), 32'd1);
        tick();
        s_waitrequest = 1'b0;
        s_readdata    = 32'hDEADBEEF;
        #1;
        chk("t1_done_wait",  32'(m0_waitrequest), 32'd0);
        chk("t1_rdata",      32'(m0_readdata),    32'hDEADBEEF);
        chk("t1_m1_rdata",   32'(m1_readdata),    32'd0);
        chk("t1_m1_wait",    32'(m1_waitrequest), 32'd1);
        tick();
        m0_read       = 1'b0;
        s_waitrequest = 1'b1;
        #1;
        chk("t1_back_idle",  32'(grant),          32'd0);
        chk("t1_s_read_off", 32'(s_read),         32'd0);

        // ---------------- simultaneous m0 read / m1 write ----------------
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();
        m0_read       = 1'b1; m0_address = 32'h200;
        m1_write      = 1'b1; m1_address = 32'h300;
        m1_writedata  = 32'hCAFEF00D;
        m1_byteenable = 4'b0011;
        s_waitrequest = 1'b0;
        s_readdata    = 32'h11111111;
        #1;
        chk("t2_idle_grant", 32'(grant),          32'd0);
        tick();
        #1;
        chk("t2_grant0",     32'(grant),          32'd1);
        chk("t2_s_read",     32'(s_read),         32'd1);
        chk("t2_s_write0",   32'(s_write),        32'd0);
        chk("t2_s_addr0",    32'(s_address),      32'h200);
        chk("t2_m0_rdata",   32'(m0_readdata),    32'h11111111);
        chk("t2_m1_blocked", 32'(m1_waitrequest), 32'd1);
        chk("t2_m1_rd_zero", 32'(m1_readdata),    32'd0);
        tick();
        m0_read = 1'b0;
        #1;
        chk("t2_bubble",     32'(grant),          32'd0);
        chk("t2_bubble_wr",  32'(s_write),        32'd0);
        tick();
        #1;
        chk("t2_grant1",     32'(grant),          32'd2);
        chk("t2_s_write1",   32'(s_write),        32'd1);
        chk("t2_s_wdata",    32'(s_writedata),    32'hCAFEF00D);
        chk("t2_s_be",       32'(s_byteenable),   32'h3);
        chk("t2_s_addr1",    32'(s_address),      32'h300);
        chk("t2_m1_wait",    32'(m1_waitrequest), 32'd0);
        tick();
        m1_write = 1'b0;
        #1;
        chk("t2_end_idle",   32'(grant),          32'd0);

        // ---------------- continuous requests: strict alternation --------
        m0_read = 1'b1; m0_address = 32'h500;
        m1_read = 1'b1; m1_address = 32'h600;
        s_waitrequest = 1'b0;
        s_readdata    = 32'h12345678;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_idle", 32'(grant), 32'd0);
            tick();
            #1;
            if (k % 2 == 0) begin
                chk("t3_grant_m0", 32'(grant),          32'd1);
                chk("t3_addr_m0",  32'(s_address),      32'h500);
                chk("t3_m1_wait",  32'(m1_waitrequest), 32'd1);
            end else begin
                chk("t3_grant_m1", 32'(grant),          32'd2);
                chk("t3_addr_m1",  32'(s_address),      32'h600);
                chk("t3_m0_wait",  32'(m0_waitrequest), 32'd1);
            end
            tick();
        end
        m0_read = 1'b0;
        m1_read = 1'b0;

        // ---------------- watchdog abort on m1 read ----------------------
        m1_read       = 1'b1;
        m1_address    = 32'h400;
        s_waitrequest = 1'b1;
        s_readdata    = 32'h0;
        tick();
        #1;
        chk("t4_grant",    32'(grant),          32'd2);
        chk("t4_s_read",   32'(s_read),         32'd1);
        chk("t4_stall1",   32'(m1_waitrequest), 32'd1);
        tick();
        #1;
        chk("t4_stall2",   32'(m1_waitrequest), 32'd1);
        tick();
        #1;
        chk("t4_stall3",   32'(m1_waitrequest), 32'd1);
        tick();
        #1;
        chk("t4_abort_wait",  32'(m1_waitrequest), 32'd0);
        chk("t4_abort_rdata", 32'(m1_readdata),    32'hFFFFFFFF);
        chk("t4_abort_sread", 32'(s_read),         32'd0);
        chk("t4_abort_grant", 32'(grant),          32'd2);
        chk("t4_no_berr_yet", 32'(bus_error),      32'd0);
        tick();
        m1_read = 1'b0;
        #1;
        chk("t4_berr",     32'(bus_error),  32'd1);
        chk("t4_errm",     32'(err_master), 32'd1);
        chk("t4_idle",     32'(grant),      32'd0);
        chk("t4_s_read",   32'(s_read),     32'd0);
        tick();
        #1;
        chk("t4_berr_1cy", 32'(bus_error),  32'd0);
        chk("t4_errm_hold",32'(err_master), 32'd1);

        // ---------------- reset in the middle of an m0 stall -------------
        m0_read       = 1'b1;
        m0_address    = 32'h700;
        s_waitrequest = 1'b1;
        tick();
        #1;
        chk("t5_grant",     32'(grant),  32'd1);
        chk("t5_s_read",    32'(s_read), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_sread", 32'(s_read),         32'd0);
        chk("t5_rst_grant", 32'(grant),          32'd0);
        chk("t5_rst_wait",  32'(m0_waitrequest), 32'd1);
        chk("t5_rst_berr",  32'(bus_error),      32'd0);
        chk("t5_rst_errm",  32'(err_master),     32'd0);
        tick();
        #1;
        chk("t5_held_berr", 32'(bus_error), 32'd0);
        chk("t5_held_grant",32'(grant),     32'd0);
        m0_read = 1'b0;
        reset_n = 1'b1;

`ifdef BUS_LOCK_EN
        // ---------------- locked m0 writes starve m1 ---------------------
        tick();
        m0_lock       = 1'b1;
        m0_write      = 1'b1; m0_address = 32'h800;
        m0_writedata  = 32'hA5A5A5A5; m0_byteenable = 4'b1111;
        m1_read       = 1'b1; m1_address = 32'h900;
        s_waitrequest = 1'b0;
        #1;
        chk("t6_idle",     32'(grant), 32'd0);
        tick();
        #1;
        chk("t6_xfer1",    32'(grant),   32'd1);
        chk("t6_s_write",  32'(s_write), 32'd1);
        tick();
        #1;
        chk("t6_xfer2",    32'(grant),          32'd1);
        chk("t6_m1_wait",  32'(m1_waitrequest), 32'd1);
        tick();
        m0_lock = 1'b0;
        #1;
        chk("t6_xfer3",    32'(grant), 32'd1);
        tick();
        m0_write = 1'b0;
        #1;
        chk("t6_bubble",   32'(grant), 32'd0);
        tick();
        #1;
        chk("t6_m1_grant", 32'(grant),     32'd2);
        chk("t6_m1_addr",  32'(s_address), 32'h900);
        m1_read = 1'b0;
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bus_arbiter2
